// File: rtl/uart_cmd_ctrl.sv
// Byte-framed command controller between a UART RX/TX pair and a small register file.
// Decodes write/read/ALU frames and sends replies through a busy-handshaked transmitter.
module uart_cmd_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              RX_ERR,
    input  logic              TX_BUSY,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              CMD_ERR,
    output logic [DATA_W-1:0] REG0,
    output logic              CTRL_BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int RES_W = 2 * DATA_W;

    localparam logic [DATA_W-1:0] OP_WRITE = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] OP_READ  = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] OP_ALU   = DATA_W'(8'hCC);

    typedef enum logic [3:0] {
        IDLE, W_ADDR, W_DATA, R_ADDR, A_OPA, A_OPB, A_FUNC,
        TX_LOAD, TX_WAIT_HI, TX_WAIT_LO
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] regfile [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [RES_W-1:0]  reply_q, reply_val;
    logic              reply_two_q, reply_two_next;
    logic              sel_q;

    logic cmd_err_next, tx_vld_next;
    logic addr_ld, opa_ld, opb_ld, reg_we, reply_ld, sel_set;

    logic              rx_bad, addr_bad;
    logic [ADDR_W-1:0] rx_addr;
    logic [RES_W-1:0]  a_w, b_w, alu_res;
    logic              alu_ok;

    assign rx_bad   = RX_D_VLD && RX_ERR;
    assign addr_bad = |(RX_P_DATA >> ADDR_W);
    assign rx_addr  = RX_P_DATA[ADDR_W-1:0];
    assign a_w      = {{DATA_W{1'b0}}, opa_q};
    assign b_w      = {{DATA_W{1'b0}}, opb_q};

    // ALU is evaluated against the incoming func byte so the result is ready on its strobe.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (RX_P_DATA[3:0])
            4'd0:    alu_res = a_w + b_w;
            4'd1:    alu_res = a_w - b_w;
            4'd2:    alu_res = a_w * b_w;
            4'd3:    alu_res = a_w & b_w;
            4'd4:    alu_res = a_w | b_w;
            4'd5:    alu_res = a_w ^ b_w;
            default: alu_ok  = 1'b0;
        endcase
        if (|(RX_P_DATA >> 4)) alu_ok = 1'b0;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        cmd_err_next   = 1'b0;
        tx_vld_next    = 1'b0;
        addr_ld        = 1'b0;
        opa_ld         = 1'b0;
        opb_ld         = 1'b0;
        reg_we         = 1'b0;
        reply_ld       = 1'b0;
        reply_val      = '0;
        reply_two_next = 1'b0;
        sel_set        = 1'b0;

        case (state)
            TX_LOAD, TX_WAIT_HI, TX_WAIT_LO: begin
                // Bytes arriving mid-reply are dropped so the reply stays intact.
                cmd_err_next = RX_D_VLD;
                if (state == TX_LOAD && !TX_BUSY) begin
                    tx_vld_next = 1'b1;
                    state_next  = TX_WAIT_HI;
                end else if (state == TX_WAIT_HI && TX_BUSY) begin
                    state_next = TX_WAIT_LO;
                end else if (state == TX_WAIT_LO && !TX_BUSY) begin
                    if (reply_two_q && !sel_q) begin
                        sel_set    = 1'b1;
                        state_next = TX_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                if (rx_bad) begin
                    cmd_err_next = 1'b1;
                    state_next   = IDLE;
                end else if (RX_D_VLD) begin
                    case (state)
                        IDLE: begin
                            if (RX_P_DATA == OP_WRITE)     state_next = W_ADDR;
                            else if (RX_P_DATA == OP_READ) state_next = R_ADDR;
                            else if (RX_P_DATA == OP_ALU)  state_next = A_OPA;
                            else                           cmd_err_next = 1'b1;
                        end
                        W_ADDR: begin
                            if (addr_bad) begin
                                cmd_err_next = 1'b1;
                                state_next   = IDLE;
                            end else begin
                                addr_ld    = 1'b1;
                                state_next = W_DATA;
                            end
                        end
                        W_DATA: begin
                            reg_we     = 1'b1;
                            state_next = IDLE;
                        end
                        R_ADDR: begin
                            if (addr_bad) begin
                                cmd_err_next = 1'b1;
                                state_next   = IDLE;
                            end else begin
                                reply_ld   = 1'b1;
                                reply_val  = {{DATA_W{1'b0}}, regfile[rx_addr]};
                                state_next = TX_LOAD;
                            end
                        end
                        A_OPA: begin
                            opa_ld     = 1'b1;
                            state_next = A_OPB;
                        end
                        A_OPB: begin
                            opb_ld     = 1'b1;
                            state_next = A_FUNC;
                        end
                        A_FUNC: begin
                            if (alu_ok) begin
                                reply_ld       = 1'b1;
                                reply_val      = alu_res;
                                reply_two_next = 1'b1;
                                state_next     = TX_LOAD;
                            end else begin
                                cmd_err_next = 1'b1;
                                state_next   = IDLE;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            reply_q     <= '0;
            reply_two_q <= 1'b0;
            sel_q       <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
            // NOTE: the register file must come out of reset cleared, so it is reset as
            // flops rather than inferred as a RAM macro.
            for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
        end else begin
            state    <= state_next;
            TX_D_VLD <= tx_vld_next;
            CMD_ERR  <= cmd_err_next;
            if (addr_ld) addr_q <= rx_addr;
            if (opa_ld)  opa_q  <= RX_P_DATA;
            if (opb_ld)  opb_q  <= RX_P_DATA;
            if (reg_we)  regfile[addr_q] <= RX_P_DATA;
            if (reply_ld) begin
                reply_q     <= reply_val;
                reply_two_q <= reply_two_next;
                sel_q       <= 1'b0;
            end else if (sel_set) begin
                sel_q <= 1'b1;
            end
            if (tx_vld_next)
                TX_P_DATA <= sel_q ? reply_q[RES_W-1:DATA_W] : reply_q[DATA_W-1:0];
        end
    end

    assign REG0      = regfile[0];
    assign CTRL_BUSY = (state != IDLE);

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width; depth is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, byte width, matching the UART data width.
REQ-003 SHALL have port CLK, input, 1 bit: single clock, the same clock as the UART_RX/UART_TX pair.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port RX_P_DATA, input, DATA_W bits: received byte.
REQ-006 SHALL have port RX_D_VLD, input, 1 bit: one-cycle strobe qualifying RX_P_DATA.
REQ-007 SHALL have port RX_ERR, input, 1 bit: parity OR framing error, qualified by RX_D_VLD.
REQ-008 SHALL have port TX_BUSY, input, 1 bit: transmitter busy.
REQ-009 SHALL have port TX_P_DATA, output, DATA_W bits: byte to transmit.
REQ-010 SHALL have port TX_D_VLD, output, 1 bit: one-cycle transmit request.
REQ-011 SHALL have port CMD_ERR, output, 1 bit: one-cycle error pulse.
REQ-012 SHALL have port REG0, output, DATA_W bits: continuous copy of register 0 (config).
REQ-013 SHALL have port CTRL_BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement a register file of 2**ADDR_W x DATA_W, written only by the write command.
REQ-015 SHALL decode frames of bytes, each byte consumed on a cycle with RX_D_VLD=1 and RX_ERR=0; frame formats:
- 0xAA,addr,data: write.
- 0xBB,addr: read; reply 1 byte.
- 0xCC,A,B,func: ALU; reply 2 bytes, LSB first.
REQ-016 SHALL use FSM states IDLE, W_ADDR, W_DATA, R_ADDR, A_OPA, A_OPB, A_FUNC, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
REQ-017 SHALL, in IDLE, go to W_ADDR on 0xAA, R_ADDR on 0xBB, A_OPA on 0xCC; any other byte pulses CMD_ERR and the FSM stays in IDLE.
REQ-018 SHALL, on an address byte with bits above ADDR_W nonzero, pulse CMD_ERR and return to IDLE with no write and no reply.
REQ-019 SHALL write the register in the cycle after the data byte strobe (W_DATA -> IDLE); REG0 updates on that same edge.
REQ-020 SHALL, for a read, load the reply buffer with regfile[addr] and go to TX_LOAD.
REQ-021 SHALL compute a 16-bit result by ALU func (low 4 bits; upper bits must be 0):
- 0: A+B, zero-extended.
- 1: A-B, 16-bit modulo.
- 2: A*B.
- 3: A&B, zero-extended.
- 4: A|B, zero-extended.
- 5: A^B, zero-extended.
- Other values: pulse CMD_ERR, return to IDLE, no reply.
REQ-022 SHALL follow this TX handshake:
- TX_LOAD: when TX_BUSY=0, drive TX_P_DATA and pulse TX_D_VLD for exactly 1 cycle, then go to TX_WAIT_HI.
- TX_WAIT_HI: wait for TX_BUSY=1.
- TX_WAIT_LO: wait for TX_BUSY=0, then go to TX_LOAD for the next byte or to IDLE after the last byte.
REQ-023 SHALL hold TX_P_DATA stable from the TX_D_VLD pulse until the next TX_LOAD.
REQ-024 SHALL drop any RX byte strobed while in TX_LOAD/TX_WAIT_HI/TX_WAIT_LO, pulse CMD_ERR, and leave the reply undisturbed.
REQ-025 SHALL, on RX_D_VLD=1 with RX_ERR=1 in any non-TX state, discard the byte, pulse CMD_ERR, and return to IDLE.
REQ-026 SHALL ignore RX_P_DATA and RX_ERR whenever RX_D_VLD=0.
REQ-027 SHALL impose no inter-byte timeout; a partial frame waits indefinitely.

Reset
REQ-028 SHALL, while RST=1 at a CLK edge, force the FSM to IDLE, clear all regfile entries, TX_P_DATA, TX_D_VLD, CMD_ERR, and CTRL_BUSY to 0, and clear REG0 to 0.
REQ-029 SHALL let a reset asserted mid-frame or mid-reply abort the operation with no further TX_D_VLD pulses; the first frame after reset decodes normally.

Verification
REQ-030 SHALL cover: bytes AA,03,5C then BB,03 -> one TX_D_VLD with TX_P_DATA=0x5C; a write to address 0 -> REG0=0x5C one cycle after the data strobe.
REQ-031 SHALL cover: CC,FF,02,02 -> two TX bytes 0xFE then 0x01 (0x01FE); CC,03,05,01 -> 0xFE then 0xFF.
REQ-032 SHALL cover: opcode 0x11, address 0x10, func 0x07 -> one CMD_ERR pulse each, no TX_D_VLD, FSM returns to IDLE.
REQ-033 SHALL cover: AA,02 then a byte with RX_ERR=1 -> CMD_ERR pulse, regfile[2] unchanged, next BB,02 replies with the old value.
REQ-034 SHALL cover: TX_BUSY held high for 20 cycles before the first reply byte -> TX_D_VLD withheld until TX_BUSY=0, exactly one pulse per byte; an RX byte during reply -> CMD_ERR, reply intact.
REQ-035 SHALL cover: RST pulsed during TX_WAIT_LO of a 2-byte ALU reply -> no second TX_D_VLD, all outputs 0, regfile cleared.
